// File: rtl/sfifo_ctrl.sv
// sfifo_ctrl: controller for the single-port FIFO memory macro (sfifo_mem).
// Owns the pointers and occupancy. Fronts the memory with a one-entry write
// buffer and a first-word-fall-through output register, and issues at most
// one memory access (read or write) per cycle.
module sfifo_ctrl #(
    parameter int BW     = 32,
    parameter int LGFLEN = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_valid,
    output logic [BW-1:0]     o_data,
    input  logic              i_rd,
    output logic              o_underflow,
    output logic [LGFLEN+1:0] o_fill,
    output logic              o_mem_wr,
    output logic [LGFLEN-1:0] o_mem_wr_addr,
    output logic [BW-1:0]     o_mem_data,
    output logic              o_mem_rd,
    output logic [LGFLEN-1:0] o_mem_rd_addr,
    input  logic [BW-1:0]     i_mem_data
);

    localparam int              DEPTH    = 1 << LGFLEN;
    localparam int              FW       = LGFLEN + 2;
    localparam logic [LGFLEN:0] MEM_FULL = (LGFLEN + 1)'(DEPTH);
    localparam logic [LGFLEN:0] CNT_ONE  = (LGFLEN + 1)'(1);
    localparam logic [LGFLEN-1:0] PTR_ONE = LGFLEN'(1);

    logic              wbuf_valid;
    logic [BW-1:0]     wbuf_data;
    logic              rd_pend;
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN-1:0] rd_ptr;
    logic [LGFLEN:0]   mem_cnt;

    logic pop;
    logic push;
    logic out_free;
    logic do_rd;
    logic do_bypass;
    logic do_wr;

    // Arbitration: memory read first, then direct bypass, then memory write.
    assign pop       = i_rd & o_valid;
    assign push      = i_wr & ~wbuf_valid;
    assign out_free  = ~o_valid | pop;
    assign do_rd     = ~rd_pend & (mem_cnt != '0) & out_free;
    assign do_bypass = wbuf_valid & (mem_cnt == '0) & ~rd_pend & out_free;
    assign do_wr     = wbuf_valid & ~do_rd & ~do_bypass & (mem_cnt < MEM_FULL);

    assign o_full        = wbuf_valid;
    assign o_mem_rd      = do_rd;
    assign o_mem_rd_addr = rd_ptr;
    assign o_mem_wr      = do_wr;
    assign o_mem_wr_addr = wr_ptr;
    assign o_mem_data    = wbuf_data;

    assign o_fill = FW'(mem_cnt) + FW'(wbuf_valid) + FW'(rd_pend) + FW'(o_valid);

    // Pointer, occupancy and read-in-flight bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd)      mem_cnt <= mem_cnt - CNT_ONE;
            else if (do_wr) mem_cnt <= mem_cnt + CNT_ONE;
            // A read is pending for exactly the cycle after it is issued.
            rd_pend <= do_rd;
        end
    end

    // Write buffer occupancy: filled by an accepted push, drained by bypass or write.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wbuf_valid <= 1'b0;
        end else if (push) begin
            wbuf_valid <= 1'b1;
        end else if (do_bypass || do_wr) begin
            wbuf_valid <= 1'b0;
        end
    end

    // Write buffer payload.
    // NOTE: data-only storage has no reset; wbuf_valid alone qualifies it.
    always_ff @(posedge i_clk) begin
        if (push) wbuf_data <= i_data;
    end

    // Output register: memory return has priority over bypass, else a pop empties it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (rd_pend) begin
            o_data  <= i_mem_data;
            o_valid <= 1'b1;
        end else if (do_bypass) begin
            o_data  <= wbuf_data;
            o_valid <= 1'b1;
        end else if (pop) begin
            o_valid <= 1'b0;
        end
    end

    // Registered error pulses for the previous cycle's request.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wr & wbuf_valid;
            o_underflow <= i_rd & ~o_valid;
        end
    end

endmodule

// File: tb/tb_sfifo_ctrl.sv
// Directed testbench for sfifo_ctrl with a behavioural model of the
// single-port memory (read priority, registered read data).
module tb_sfifo_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr;
    logic [7:0] data;
    logic       full;
    logic       overflow;
    logic       valid;
    logic [7:0] q;
    logic       rd;
    logic       underflow;
    logic [3:0] fill;
    logic       mem_wr;
    logic [1:0] mem_wr_addr;
    logic [7:0] mem_data;
    logic       mem_rd;
    logic [1:0] mem_rd_addr;
    logic [7:0] mem_q;

    int n_assert = 0;
    int n_fail   = 0;

    // memory model and access monitor
    logic [7:0] mem [0:3];
    logic [1:0] wr_log [0:255];
    int wr_count   = 0;
    int rd_count   = 0;
    int both_high  = 0;

    always #5 clk = ~clk;

    sfifo_ctrl #(.BW(8), .LGFLEN(2)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_wr         (wr),
        .i_data       (data),
        .o_full       (full),
        .o_overflow   (overflow),
        .o_valid      (valid),
        .o_data       (q),
        .i_rd         (rd),
        .o_underflow  (underflow),
        .o_fill       (fill),
        .o_mem_wr     (mem_wr),
        .o_mem_wr_addr(mem_wr_addr),
        .o_mem_data   (mem_data),
        .o_mem_rd     (mem_rd),
        .o_mem_rd_addr(mem_rd_addr),
        .i_mem_data   (mem_q)
    );

    always @(posedge clk) begin
        if (mem_rd && mem_wr) both_high++;
        if (mem_rd) begin
            mem_q <= mem[mem_rd_addr];
            rd_count++;
        end
        if (mem_wr && !mem_rd) begin
            mem[mem_wr_addr] <= mem_data;
            if (wr_count < 256) wr_log[wr_count] = mem_wr_addr;
            wr_count++;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        int guard = 0;
        while (full && guard < 20) begin cyc(); guard++; end
        if (full) begin
            n_assert++; n_fail++;
            $display("FAIL push_wait: o_full stuck at 1, wanted 0");
        end
        wr = 1'b1; data = d;
        cyc();
        wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr = 1'b0; rd = 1'b0; data = '0;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
        n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
        n_assert++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
        n_assert++; if (fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_assert++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", q); end
        n_assert++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%0b unf=%0b want 0 0", overflow, underflow); end
        n_assert++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem: got wr=%0b rd=%0b want 0 0", mem_wr, mem_rd); end
    endtask

    task automatic test_bypass();
        int wbase = wr_count;
        int rbase = rd_count;
        wr = 1'b1; data = 8'hA1;
        cyc();
        wr = 1'b0;
        n_assert++; if (full !== 1'b1) begin n_fail++; $display("FAIL bypass_full: got %0b want 1", full); end
        n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bypass_early_valid: got %0b want 0", valid); end
        cyc();
        n_assert++; if (valid !== 1'b1 || q !== 8'hA1) begin n_fail++; $display("FAIL bypass_out: got valid=%0b data=%h want 1 a1", valid, q); end
        n_assert++; if (full !== 1'b0 || fill !== 4'd1) begin n_fail++; $display("FAIL bypass_fill: got full=%0b fill=%0d want 0 1", full, fill); end
        n_assert++; if (wr_count != wbase || rd_count != rbase) begin n_fail++; $display("FAIL bypass_no_mem: got wr=%0d rd=%0d accesses want 0 0", wr_count - wbase, rd_count - rbase); end
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        n_assert++; if (valid !== 1'b0 || fill !== 4'd0) begin n_fail++; $display("FAIL bypass_pop: got valid=%0b fill=%0d want 0 0", valid, fill); end
    endtask

    task automatic test_fill_overflow();
        int wbase = wr_count;
        int n = 0;
        for (int k = 1; k <= 6; k++) push(8'(k));
        n_assert++; if (fill !== 4'd6 || full !== 1'b1) begin n_fail++; $display("FAIL fill_six: got fill=%0d full=%0b want 6 1", fill, full); end
        n_assert++; if (wr_count - wbase != 4) begin n_fail++; $display("FAIL fill_mem_writes: got %0d want 4", wr_count - wbase); end
        for (int i = 0; i < 4; i++) begin
            n_assert++; if (wr_log[wbase + i] !== 2'(i)) begin n_fail++; $display("FAIL fill_wr_addr%0d: got %0d want %0d", i, wr_log[wbase + i], i); end
        end
        wr = 1'b1; data = 8'h07;
        cyc();
        wr = 1'b0;
        n_assert++; if (overflow !== 1'b1 || fill !== 4'd6) begin n_fail++; $display("FAIL overflow_pulse: got ovf=%0b fill=%0d want 1 6", overflow, fill); end
        cyc();
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %0b want 0", overflow); end
        rd = 1'b1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            if (valid) begin
                n_assert++; if (q !== 8'(n + 1)) begin n_fail++; $display("FAIL drain_word%0d: got %h want %h", n, q, 8'(n + 1)); end
                n++;
            end
            cyc();
        end
        rd = 1'b0;
        n_assert++; if (n != 6 || fill !== 4'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL drain_end: got words=%0d fill=%0d valid=%0b want 6 0 0", n, fill, valid); end
    endtask

    task automatic test_wrap();
        int wbase = wr_count;
        int pushed = 0;
        int popped = 0;
        for (int c = 0; c < 400 && popped < 24; c++) begin
            wr = (pushed < 24) && !full;
            if (wr) data = 8'(8'h10 + pushed);
            rd = valid && ((pushed >= 24) || (fill >= 4'd4));
            if (rd) begin
                n_assert++; if (q !== 8'(8'h10 + popped)) begin n_fail++; $display("FAIL wrap_order%0d: got %h want %h", popped, q, 8'(8'h10 + popped)); end
                popped++;
            end
            if (wr) pushed++;
            cyc();
        end
        wr = 1'b0; rd = 1'b0;
        n_assert++; if (popped != 24 || fill !== 4'd0) begin n_fail++; $display("FAIL wrap_done: got popped=%0d fill=%0d want 24 0", popped, fill); end
        n_assert++; if (wr_count - wbase < 20) begin n_fail++; $display("FAIL wrap_mem_writes: got %0d want >=20", wr_count - wbase); end
    endtask

    task automatic test_rd_wr_conflict();
        int n = 0;
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        // wbuf holds 0x34, memory holds 0x32 0x33, output holds 0x31
        rd = 1'b1;
        #1;
        n_assert++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL conflict_rd_first: got rd=%0b wr=%0b want 1 0", mem_rd, mem_wr); end
        cyc();
        rd = 1'b0;
        #1;
        n_assert++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL conflict_wr_deferred: got rd=%0b wr=%0b want 0 1", mem_rd, mem_wr); end
        cyc();
        n_assert++; if (valid !== 1'b1 || q !== 8'h32 || fill !== 4'd3) begin n_fail++; $display("FAIL conflict_head: got valid=%0b data=%h fill=%0d want 1 32 3", valid, q, fill); end
        rd = 1'b1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (valid) begin
                n_assert++; if (q !== 8'(8'h32 + n)) begin n_fail++; $display("FAIL conflict_word%0d: got %h want %h", n, q, 8'(8'h32 + n)); end
                n++;
            end
            cyc();
        end
        rd = 1'b0;
        n_assert++; if (n != 3 || fill !== 4'd0) begin n_fail++; $display("FAIL conflict_drain: got words=%0d fill=%0d want 3 0", n, fill); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) push(8'(8'h41 + k));
        cyc();
        n_assert++; if (fill !== 4'd5) begin n_fail++; $display("FAIL midreset_pre_fill: got %0d want 5", fill); end
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        n_assert++; if (fill !== 4'd4 || valid !== 1'b0) begin n_fail++; $display("FAIL midreset_inflight: got fill=%0d valid=%0b want 4 0", fill, valid); end
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        n_assert++; if (valid !== 1'b0 || full !== 1'b0 || fill !== 4'd0) begin n_fail++; $display("FAIL midreset_clear: got valid=%0b full=%0b fill=%0d want 0 0 0", valid, full, fill); end
        cyc();
        n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_discard: got valid=%0b want 0", valid); end
        push(8'h5A);
        cyc();
        n_assert++; if (valid !== 1'b1 || q !== 8'h5A) begin n_fail++; $display("FAIL midreset_bypass: got valid=%0b data=%h want 1 5a", valid, q); end
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        n_assert++; if (fill !== 4'd0) begin n_fail++; $display("FAIL midreset_pop: got fill=%0d want 0", fill); end
    endtask

    task automatic test_underflow();
        int wbase;
        cyc();
        n_assert++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_idle: got %0b want 0", underflow); end
        rd = 1'b1;
        cyc();
        rd = 1'b0;
        n_assert++; if (underflow !== 1'b1 || fill !== 4'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got unf=%0b fill=%0d valid=%0b want 1 0 0", underflow, fill, valid); end
        cyc();
        n_assert++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %0b want 0", underflow); end
        // write pointer is 0 after the reset; the underflow must not have moved it
        wbase = wr_count;
        push(8'h71); push(8'h72);
        cyc();
        n_assert++; if (wr_count - wbase != 1 || wr_log[wbase] !== 2'd0) begin n_fail++; $display("FAIL underflow_ptr: got writes=%0d addr=%0d want 1 0", wr_count - wbase, wr_log[wbase]); end
        n_assert++; if (q !== 8'h71 || fill !== 4'd2) begin n_fail++; $display("FAIL underflow_after: got data=%h fill=%0d want 71 2", q, fill); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_fill_overflow();
        test_wrap();
        test_rd_wr_conflict();
        test_reset_mid();
        test_underflow();
        n_assert++; if (both_high != 0) begin n_fail++; $display("FAIL rd_wr_exclusive: got %0d cycles with both high want 0", both_high); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
